// File: rtl/rv_memory_pkg.sv
// Shared encodings for the memory stage: result select, access sizes,
// funct3 values, FSM states and the alignment rule used by both the
// stage register logic and the lane aligner.
package rv_memory_pkg;

    // Write-back result select
    localparam logic [1:0] RES_SRC_ALU = 2'b00;
    localparam logic [1:0] RES_SRC_MEM = 2'b01;
    localparam logic [1:0] RES_SRC_PC4 = 2'b10;

    // Access size lives in funct3[1:0]; funct3[2] selects zero-extension
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Halfword accesses need an even address, word accesses a word-aligned one
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            SIZE_H:  return off[0];
            SIZE_W:  return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane aligner: store byte enables and replicated store data,
// load byte/half extraction with sign or zero extension, and misalignment.
module rv_lsu_align
    import rv_memory_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    assign shifted    = rdata >> {offset, 3'b000};
    assign misaligned = is_misaligned(funct3, offset);

    // Size-dependent lane selection for stores and extraction for loads
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        sel       = 4'hF;
        wdata     = rs2;
        load_data = rdata;
        case (funct3[1:0])
            SIZE_B: begin
                sel       = 4'b0001 << offset;
                wdata     = {4{rs2[7:0]}};
                load_data = funct3[2] ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                sel       = 4'b0011 << offset;
                wdata     = {2{rs2[15:0]}};
                load_data = funct3[2] ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_memory.sv
// Memory pipeline stage: registers the execute bundle, performs one load or
// store at a time on a request/ack bus, stalls upstream while the access is
// pending, and presents the write-back result.
module rv_memory
    import rv_memory_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_alu_result,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [4:0]  i_rd,
    input  logic [29:0] i_pc_p4,
    input  logic [1:0]  i_res_src,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs2_val,
    output logic        o_stall,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [29:0] o_dbus_addr,
    output logic [3:0]  o_dbus_sel,
    output logic [31:0] o_dbus_wdata,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdata,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic [31:0] o_result,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t             state;
    logic [31:0]        r_alu_result;
    logic               r_reg_write;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [4:0]         r_rd;
    logic [29:0]        r_pc_p4;
    logic [1:0]         r_res_src;
    logic [2:0]         r_funct3;
    logic [31:0]        r_rs2_val;
    logic [31:0]        r_rdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bus_err;

    logic               capture;
    logic               in_mem_op;
    logic               mem_op;
    logic [3:0]         st_sel;
    logic [31:0]        st_wdata;
    logic [31:0]        load_data;
    logic               lsu_misaligned;
    logic [31:0]        result;

    assign capture   = (state != ST_REQ);
    assign in_mem_op = i_mem_read | i_mem_write;
    assign mem_op    = r_mem_read | r_mem_write;

    rv_lsu_align u_align (
        .funct3     (r_funct3),
        .offset     (r_alu_result[1:0]),
        .rs2        (r_rs2_val),
        .rdata      (r_rdata),
        .sel        (st_sel),
        .wdata      (st_wdata),
        .load_data  (load_data),
        .misaligned (lsu_misaligned)
    );

    // Stage register capture plus the IDLE/REQ/DONE access sequencer
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (i_reset) begin
            state        <= ST_IDLE;
            r_alu_result <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_rd         <= '0;
            r_pc_p4      <= '0;
            r_res_src    <= '0;
            r_funct3     <= '0;
            r_rs2_val    <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
            r_bus_err    <= 1'b0;
        end else if (capture) begin
            r_alu_result <= i_alu_result;
            r_reg_write  <= i_reg_write;
            r_mem_read   <= i_mem_read;
            r_mem_write  <= i_mem_write;
            r_rd         <= i_rd;
            r_pc_p4      <= i_pc_p4;
            r_res_src    <= i_res_src;
            r_funct3     <= i_funct3;
            r_rs2_val    <= i_rs2_val;
            r_cnt        <= '0;
            r_bus_err    <= 1'b0;
            state        <= (in_mem_op && !is_misaligned(i_funct3, i_alu_result[1:0]))
                            ? ST_REQ : ST_IDLE;
        end else begin
            if (i_dbus_ack) begin
                r_rdata <= i_dbus_rdata;
                state   <= ST_DONE;
            end else if (TIMEOUT > 0 && r_cnt == CNT_MAX) begin
                r_bus_err <= 1'b1;
                state     <= ST_DONE;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Write-back value selection
    always_comb begin
        result = '0;
        case (r_res_src)
            RES_SRC_ALU: result = r_alu_result;
            RES_SRC_MEM: result = load_data;
            RES_SRC_PC4: result = {r_pc_p4, 2'b00};
            default:     result = '0;
        endcase
    end

    // Bus outputs are only driven while a request is outstanding
    assign o_stall      = (state == ST_REQ);
    assign o_dbus_req   = o_stall;
    assign o_dbus_we    = o_stall & r_mem_write;
    assign o_dbus_addr  = o_stall ? r_alu_result[31:2] : '0;
    assign o_dbus_sel   = o_stall ? (r_mem_write ? st_sel : 4'hF) : 4'h0;
    assign o_dbus_wdata = (o_stall && r_mem_write) ? st_wdata : '0;

    // A misaligned access never leaves IDLE, so its pulse lasts exactly one cycle
    assign o_misaligned = mem_op & lsu_misaligned & (state == ST_IDLE);
    assign o_bus_err    = (state == ST_DONE) & r_bus_err;
    assign o_reg_write  = r_reg_write & ~o_stall & ~o_misaligned & ~o_bus_err;
    assign o_rd         = r_rd;
    assign o_result     = result;

endmodule

// File: tb/tb_rv_memory.sv
// Scoreboard bench for rv_memory: stimulus pushes expected bus requests and
// write-back events; a negedge monitor pops and compares them.
module tb_rv_memory;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_alu_result;
    logic        i_reg_write, i_mem_read, i_mem_write;
    logic [4:0]  i_rd;
    logic [29:0] i_pc_p4;
    logic [1:0]  i_res_src;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs2_val;
    logic        o_stall, o_dbus_req, o_dbus_we;
    logic [29:0] o_dbus_addr;
    logic [3:0]  o_dbus_sel;
    logic [31:0] o_dbus_wdata;
    logic        i_dbus_ack;
    logic [31:0] i_dbus_rdata;
    logic        o_reg_write;
    logic [4:0]  o_rd;
    logic [31:0] o_result;
    logic        o_misaligned, o_bus_err;

    rv_memory #(.TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_alu_result(i_alu_result), .i_reg_write(i_reg_write),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_rd(i_rd), .i_pc_p4(i_pc_p4), .i_res_src(i_res_src),
        .i_funct3(i_funct3), .i_rs2_val(i_rs2_val),
        .o_stall(o_stall), .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we),
        .o_dbus_addr(o_dbus_addr), .o_dbus_sel(o_dbus_sel),
        .o_dbus_wdata(o_dbus_wdata), .i_dbus_ack(i_dbus_ack),
        .i_dbus_rdata(i_dbus_rdata), .o_reg_write(o_reg_write),
        .o_rd(o_rd), .o_result(o_result),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       tag;
        bit          is_bus;
        logic [29:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        we;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] result;
        bit          chk_res;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        prev_req = 1'b0;
    logic [29:0] held_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_bus(input string tag, input logic [29:0] addr, input logic [3:0] sel,
                            input logic [31:0] wdata, input logic we);
        exp_t e;
        e = '{tag: tag, is_bus: 1'b1, addr: addr, sel: sel, wdata: wdata, we: we,
              rw: 1'b0, rd: '0, result: '0, chk_res: 1'b0, mis: 1'b0, err: 1'b0};
        sb.push_back(e);
    endtask

    task automatic push_wb(input string tag, input logic rw, input logic [4:0] rd,
                           input logic [31:0] result, input bit chk_res,
                           input logic mis, input logic err);
        exp_t e;
        e = '{tag: tag, is_bus: 1'b0, addr: '0, sel: '0, wdata: '0, we: 1'b0,
              rw: rw, rd: rd, result: result, chk_res: chk_res, mis: mis, err: err};
        sb.push_back(e);
    endtask

    task automatic pop_check(input bit is_bus);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_%s_event: got event, expected none", is_bus ? "bus" : "wb");
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_kind"}, 32'(is_bus), 32'(e.is_bus));
        if (is_bus) begin
            check({e.tag, "_addr"}, 32'(o_dbus_addr), 32'(e.addr));
            check({e.tag, "_sel"}, 32'(o_dbus_sel), 32'(e.sel));
            check({e.tag, "_we"}, 32'(o_dbus_we), 32'(e.we));
            if (e.we) check({e.tag, "_wdata"}, o_dbus_wdata, e.wdata);
        end else begin
            check({e.tag, "_reg_write"}, 32'(o_reg_write), 32'(e.rw));
            check({e.tag, "_rd"}, 32'(o_rd), 32'(e.rd));
            check({e.tag, "_misaligned"}, 32'(o_misaligned), 32'(e.mis));
            check({e.tag, "_bus_err"}, 32'(o_bus_err), 32'(e.err));
            if (e.chk_res) check({e.tag, "_result"}, o_result, e.result);
        end
    endtask

    // Monitor: new request edges and visible write-back events consume expectations
    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_dbus_req && !prev_req) begin
                pop_check(1'b1);
                held_addr = o_dbus_addr;
            end else if (o_dbus_req) begin
                check("bus_addr_stable", 32'(o_dbus_addr), 32'(held_addr));
            end
            if (o_reg_write || o_misaligned || o_bus_err) pop_check(1'b0);
        end
        prev_req = o_dbus_req;
    end

    task automatic set_nop();
        i_alu_result = '0; i_reg_write = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_rd = '0; i_pc_p4 = '0; i_res_src = 2'b00; i_funct3 = 3'b000; i_rs2_val = '0;
    endtask

    // Drive one instruction, then answer the bus (optionally) and count stall cycles
    task automatic do_op(input string tag, input logic [31:0] alu, input logic rw,
                         input logic mr, input logic mw, input logic [4:0] rd,
                         input logic [29:0] pc, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [31:0] rs2, input bit ack_en, input int ack_wait,
                         input logic [31:0] rdata, input int exp_stall);
        int n;
        i_alu_result = alu; i_reg_write = rw; i_mem_read = mr; i_mem_write = mw;
        i_rd = rd; i_pc_p4 = pc; i_res_src = rs; i_funct3 = f3; i_rs2_val = rs2;
        @(posedge i_clk); #1;
        set_nop();
        n = 0;
        while (o_stall && n < 64) begin
            if (ack_en && n == ack_wait) begin
                i_dbus_ack = 1'b1;
                i_dbus_rdata = rdata;
            end
            @(posedge i_clk); #1;
            i_dbus_ack = 1'b0;
            n++;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1;
        i_dbus_ack = 1'b0;
        i_dbus_rdata = '0;
        set_nop();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_stall", 32'(o_stall), 0);
        check("rst_req", 32'(o_dbus_req), 0);
        check("rst_bus", {o_dbus_we, o_dbus_sel, o_dbus_addr[26:0]}, 0);
        check("rst_wdata", o_dbus_wdata, 0);
        check("rst_wb", {25'b0, o_reg_write, o_misaligned, o_bus_err, o_rd[3:0]}, 0);
        check("rst_rd_msb", 32'(o_rd), 0);
        check("rst_result", o_result, 0);
        i_reset = 1'b0;

        // ALU op
        push_wb("add", 1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
        do_op("add", 32'h0000_1234, 1, 0, 0, 5'd5, 30'h0, 2'b00, 3'b000, 0, 0, 0, 0, 0);

        // LW, ack after two wait cycles
        push_bus("lw", 30'h040, 4'hF, 32'h0, 1'b0);
        push_wb("lw", 1'b1, 5'd6, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        do_op("lw", 32'h100, 1, 1, 0, 5'd6, 30'h0, 2'b01, 3'b010, 0, 1, 2, 32'hDEAD_BEEF, 3);

        // LB / LBU on byte lane 3, ack in the first REQ cycle
        push_bus("lb", 30'h040, 4'hF, 32'h0, 1'b0);
        push_wb("lb", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
        do_op("lb", 32'h103, 1, 1, 0, 5'd7, 30'h0, 2'b01, 3'b000, 0, 1, 0, 32'h80AA_55CC, 1);
        push_bus("lbu", 30'h040, 4'hF, 32'h0, 1'b0);
        push_wb("lbu", 1'b1, 5'd7, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
        do_op("lbu", 32'h103, 1, 1, 0, 5'd7, 30'h0, 2'b01, 3'b100, 0, 1, 0, 32'h80AA_55CC, 1);

        // LH upper half (sign) and LHU lower half (zero)
        push_bus("lh", 30'h040, 4'hF, 32'h0, 1'b0);
        push_wb("lh", 1'b1, 5'd3, 32'hFFFF_80AA, 1'b1, 1'b0, 1'b0);
        do_op("lh", 32'h102, 1, 1, 0, 5'd3, 30'h0, 2'b01, 3'b001, 0, 1, 0, 32'h80AA_55CC, 1);
        push_bus("lhu", 30'h040, 4'hF, 32'h0, 1'b0);
        push_wb("lhu", 1'b1, 5'd4, 32'h0000_55CC, 1'b1, 1'b0, 1'b0);
        do_op("lhu", 32'h100, 1, 1, 0, 5'd4, 30'h0, 2'b01, 3'b101, 0, 1, 0, 32'h80AA_55CC, 1);

        // Stores: no write-back event expected
        push_bus("sh", 30'h080, 4'b1100, 32'hBEEF_BEEF, 1'b1);
        do_op("sh", 32'h202, 0, 0, 1, 5'd0, 30'h0, 2'b00, 3'b001, 32'h0000_BEEF, 1, 1, 0, 2);
        push_bus("sb", 30'h080, 4'b0010, 32'h7878_7878, 1'b1);
        do_op("sb", 32'h201, 0, 0, 1, 5'd0, 30'h0, 2'b00, 3'b000, 32'h1234_5678, 1, 0, 0, 1);
        push_bus("sw", 30'h081, 4'hF, 32'hCAFE_F00D, 1'b1);
        do_op("sw", 32'h204, 0, 0, 1, 5'd0, 30'h0, 2'b00, 3'b010, 32'hCAFE_F00D, 1, 0, 0, 1);

        // Misaligned LW: no request, pulse, no write-back
        push_wb("lw_mis", 1'b0, 5'd8, 32'h0, 1'b0, 1'b1, 1'b0);
        do_op("lw_mis", 32'h102, 1, 1, 0, 5'd8, 30'h0, 2'b01, 3'b010, 0, 1, 0, 32'h1111_1111, 0);

        // Timeout: four REQ cycles then bus error
        push_bus("tmo", 30'h0C0, 4'hF, 32'h0, 1'b0);
        push_wb("tmo", 1'b0, 5'd9, 32'h0, 1'b0, 1'b0, 1'b1);
        do_op("tmo", 32'h300, 1, 1, 0, 5'd9, 30'h0, 2'b01, 3'b010, 0, 0, 0, 0, 4);

        // pc+4 select and the unused select encoding
        push_wb("pc4", 1'b1, 5'd10, 32'h0000_1000, 1'b1, 1'b0, 1'b0);
        do_op("pc4", 32'h5555, 1, 0, 0, 5'd10, 30'h400, 2'b10, 3'b000, 0, 0, 0, 0, 0);
        push_wb("rs11", 1'b1, 5'd11, 32'h0, 1'b1, 1'b0, 1'b0);
        do_op("rs11", 32'h5555, 1, 0, 0, 5'd11, 30'h400, 2'b11, 3'b000, 0, 0, 0, 0, 0);

        // Reset during the second REQ cycle; late ack must be ignored
        push_bus("rst_lw", 30'h050, 4'hF, 32'h0, 1'b0);
        i_alu_result = 32'h140; i_reg_write = 1'b1; i_mem_read = 1'b1;
        i_rd = 5'd12; i_res_src = 2'b01; i_funct3 = 3'b010;
        @(posedge i_clk); #1;
        set_nop();
        @(posedge i_clk); #1;
        check("rst_lw_in_req", 32'(o_stall), 1);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        check("rst_lw_req_cleared", 32'(o_dbus_req), 0);
        check("rst_lw_stall_cleared", 32'(o_stall), 0);
        i_dbus_ack = 1'b1;
        i_dbus_rdata = 32'h7777_7777;
        @(posedge i_clk); #1;
        i_dbus_ack = 1'b0;
        check("late_ack_req", 32'(o_dbus_req), 0);
        check("late_ack_reg_write", 32'(o_reg_write), 0);
        check("late_ack_result", o_result, 0);

        repeat (3) @(posedge i_clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
